cpu_ram_port: RTL and testbench

CPU_RAM_PORT -- requirements
Module: cpu_ram_port

---
 rtl/cpu_ram_port_pkg.sv | 16 +
 rtl/cpu_ram_port_if.sv | 25 ++
 rtl/cpu_ram_port_byte_fifo.sv | 70 +++++++
 rtl/cpu_ram_port.sv | 112 +++++++++++
 tb/tb_cpu_ram_port.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_ram_port_pkg.sv
// Shared constants and helpers for the cpu_ram_port slice.
// The MMIO output FIFO is only built when CPU_RAM_MMIO_EN is defined.
package cpu_ram_port_pkg;

    localparam logic [31:0] IO_ADDR_DEFAULT = 32'h0003_0000;
    localparam logic        ENABLE          = 1'b1;
    localparam logic        DISABLE         = 1'b0;
    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;

    typedef logic [7:0] byte_t;

    function automatic byte_t status_byte(input logic ovf, input logic [3:0] count);
        return {ovf, 3'b000, count};
    endfunction

endpackage

// File: rtl/cpu_ram_port_if.sv
// CPU data-port bus plus the memory-mapped output byte stream of cpu_ram_port.
interface cpu_ram_port_if;

    logic        re_i;
    logic [31:0] raddr_i;
    logic [7:0]  rdata_o;
    logic        we_i;
    logic [31:0] waddr_i;
    logic [7:0]  wdata_i;
    logic        io_valid_o;
    logic [7:0]  io_data_o;
    logic        io_ready_i;
    logic        io_ovf_o;

    modport master (
        output re_i, raddr_i, we_i, waddr_i, wdata_i, io_ready_i,
        input  rdata_o, io_valid_o, io_data_o, io_ovf_o
    );

    modport slave (
        input  re_i, raddr_i, we_i, waddr_i, wdata_i, io_ready_i,
        output rdata_o, io_valid_o, io_data_o, io_ovf_o
    );

endinterface

// File: rtl/cpu_ram_port_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; a push to a full FIFO is accepted only
// when a pop happens on the same edge. DEPTH must be a power of two, >= 2.
module byte_fifo
    import cpu_ram_port_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   dclk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  byte_t                  din,
    output byte_t                  dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    byte_t       r_data [DEPTH];
    logic        w_pop_ok;
    logic        w_push_ok;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign count = r_wptr - r_rptr;
    assign dout  = r_data[r_rptr[AW-1:0]];

    // Accept logic: the slot freed by a same-edge pop lets a full FIFO take a push
    always_comb begin
        w_pop_ok  = DISABLE;
        w_push_ok = DISABLE;
        if (pop && !empty) begin
            w_pop_ok = ENABLE;
        end else begin
            w_pop_ok = DISABLE;
        end
        if (push && (!full || w_pop_ok)) begin
            w_push_ok = ENABLE;
        end else begin
            w_push_ok = DISABLE;
        end
    end

    // Pointer registers
    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Payload storage; contents are meaningless until pointers say otherwise
    always_ff @(posedge dclk) begin
        if (w_push_ok) begin
            r_data[r_wptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/cpu_ram_port.sv
// Byte RAM behind a CPU data port, with an optional memory-mapped output FIFO
// at IO_ADDR (enabled by defining CPU_RAM_MMIO_EN).
module cpu_ram_port
    import cpu_ram_port_pkg::*;
#(
    parameter int          ADDR_W     = 17,
    parameter logic [31:0] IO_ADDR    = IO_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic           dclk,
    input  logic           rst,
    cpu_ram_port_if.slave  bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    byte_t              r_mem [2**ADDR_W];
    byte_t              r_rdata;
    logic [ADDR_W-1:0]  w_ridx;
    logic [ADDR_W-1:0]  w_widx;
    logic               w_io_wr;
    logic               w_io_rd;
    logic               w_mem_we;
    logic               w_bypass;
    byte_t              w_status;
    byte_t              w_rd_next;

`ifdef CPU_RAM_MMIO_EN
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic [CW-1:0]      w_count;
    byte_t              w_head;
    logic               r_ovf;

    assign w_io_wr = bus.we_i && (bus.waddr_i == IO_ADDR);
    assign w_io_rd = bus.re_i && (bus.raddr_i == IO_ADDR);
    assign w_pop   = !w_empty && bus.io_ready_i;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .dclk  (dclk),
        .rst   (rst),
        .push  (w_io_wr),
        .pop   (w_pop),
        .din   (bus.wdata_i),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Sticky overflow: a dropped push leaves a mark until reset
    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            r_ovf <= DISABLE;
        end else if (w_io_wr && w_full && !w_pop) begin
            r_ovf <= ENABLE;
        end
    end

    assign w_status       = status_byte(r_ovf, 4'(w_count));
    assign bus.io_valid_o = !w_empty;
    assign bus.io_data_o  = w_head;
    assign bus.io_ovf_o   = r_ovf;
`else
    logic w_unused_mmio;

    assign w_io_wr        = DISABLE;
    assign w_io_rd        = DISABLE;
    assign w_status       = ZERO_WORD[7:0];
    assign bus.io_valid_o = DISABLE;
    assign bus.io_data_o  = ZERO_WORD[7:0];
    assign bus.io_ovf_o   = DISABLE;
    assign w_unused_mmio  = ^{bus.io_ready_i, bus.raddr_i[31:ADDR_W], bus.waddr_i[31:ADDR_W], IO_ADDR};
`endif

    assign w_ridx   = bus.raddr_i[ADDR_W-1:0];
    assign w_widx   = bus.waddr_i[ADDR_W-1:0];
    assign w_mem_we = bus.we_i && !w_io_wr && !rst;
    assign w_bypass = w_mem_we && (w_widx == w_ridx);

    // Read source select: status register, write-through bypass, or storage
    always_comb begin
        w_rd_next = r_rdata;
        if (w_io_rd) begin
            w_rd_next = w_status;
        end else if (w_bypass) begin
            w_rd_next = bus.wdata_i;
        end else begin
            w_rd_next = r_mem[w_ridx];
        end
    end

    // Storage write port, kept reset-free so it maps onto block RAM
    always_ff @(posedge dclk) begin
        if (w_mem_we) begin
            r_mem[w_widx] <= bus.wdata_i;
        end
    end

    // Registered read data, held while re_i is low
    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            r_rdata <= ZERO_WORD[7:0];
        end else if (bus.re_i) begin
            r_rdata <= w_rd_next;
        end
    end

    assign bus.rdata_o = r_rdata;

endmodule

// File: tb/tb_cpu_ram_port.sv
// Self-checking bench for cpu_ram_port: queue/array reference model checked
// every cycle, directed literal checks, then randomized traffic.
`timescale 1ns/1ps
module tb_cpu_ram_port;
    import cpu_ram_port_pkg::*;

    localparam int          ADDR_W = 17;
    localparam logic [31:0] IO_A   = 32'h0003_0000;
    localparam int          DEPTH  = 4;
    localparam int unsigned MASK   = (1 << ADDR_W) - 1;
`ifdef CPU_RAM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic dclk = 1'b0;
    logic rst  = 1'b1;

    cpu_ram_port_if bus();

    cpu_ram_port #(.ADDR_W(ADDR_W), .IO_ADDR(IO_A), .FIFO_DEPTH(DEPTH)) dut (
        .dclk (dclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    always #5 dclk = ~dclk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [7:0] m_mem [int unsigned];
    logic [7:0] m_q [$];
    logic       m_ovf   = 1'b0;
    logic [7:0] m_rdata = 8'h00;

    logic [16:0] pool [8] = '{17'h00010, 17'h00011, 17'h10000, 17'h1FFFF,
                              17'h00100, 17'h0ABCD, 17'h00000, 17'h10010};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_rdata = 8'h00;
    endfunction

    function automatic void model_step();
        int unsigned cnt = m_q.size();
        bit popped = 1'b0;
        int unsigned wi = bus.waddr_i & MASK;
        int unsigned ri = bus.raddr_i & MASK;
        bit io_w = MMIO && bus.we_i && (bus.waddr_i == IO_A);
        bit io_r = MMIO && (bus.raddr_i == IO_A);
        if (bus.we_i && !io_w) m_mem[wi] = bus.wdata_i;
        if (bus.re_i) m_rdata = io_r ? {m_ovf, 3'b000, 4'(cnt)} : m_mem[ri];
        if (bus.io_ready_i && cnt > 0) begin
            void'(m_q.pop_front());
            popped = 1'b1;
        end
        if (io_w) begin
            if (cnt == DEPTH && !popped) m_ovf = 1'b1;
            else m_q.push_back(bus.wdata_i);
        end
    endfunction

    task automatic cycle(input logic re, input logic [31:0] ra, input logic we,
                         input logic [31:0] wa, input logic [7:0] wd, input logic rdy);
        bus.re_i = re; bus.raddr_i = ra; bus.we_i = we;
        bus.waddr_i = wa; bus.wdata_i = wd; bus.io_ready_i = rdy;
        @(posedge dclk);
        model_step();
        @(negedge dclk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [14:0] hi = 15'($urandom_range(0, 32767));
        return {hi, pool[$urandom_range(0, 7)]};
    endfunction

    // Per-cycle comparison of every output against the reference model
    always @(negedge dclk) begin
        if (cmp_en && !rst) begin
            chk("rdata", bus.rdata_o, m_rdata);
            chk("io_valid", {7'b0, bus.io_valid_o}, {7'b0, m_q.size() != 0});
            chk("io_ovf", {7'b0, bus.io_ovf_o}, {7'b0, m_ovf});
            if (m_q.size() != 0) chk("io_data", bus.io_data_o, m_q[0]);
        end
    end

    initial begin
        logic [7:0] exp4 [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        bus.re_i = 1'b0; bus.raddr_i = 32'h0; bus.we_i = 1'b0;
        bus.waddr_i = 32'h0; bus.wdata_i = 8'h00; bus.io_ready_i = 1'b0;
        #12;
        chk("reset rdata", bus.rdata_o, 8'h00);
        chk("reset valid", {7'b0, bus.io_valid_o}, 8'h00);
        chk("reset ovf", {7'b0, bus.io_ovf_o}, 8'h00);
        @(negedge dclk);
        rst = 1'b0;
        cmp_en = 1'b1;

        // write then read back
        cycle(1'b0, 32'h0, 1'b1, 32'h10, 8'hA5, 1'b0);
        cycle(1'b1, 32'h10, 1'b0, 32'h0, 8'h00, 1'b0);
        chk("rd A5", bus.rdata_o, 8'hA5);

        // word as four bytes, little-endian readback
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 32'h100 + 32'(i), exp4[i], 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'h100 + 32'(i), 1'b0, 32'h0, 8'h00, 1'b0);
            chk("word byte", bus.rdata_o, exp4[i]);
        end

        cycle(1'b1, 32'h20, 1'b1, 32'h20, 8'h5C, 1'b0);
        chk("bypass", bus.rdata_o, 8'h5C);

        // hold when re_i low
        cycle(1'b0, 32'h10, 1'b0, 32'h0, 8'h00, 1'b0);
        chk("hold", bus.rdata_o, 8'h5C);

        // address wrap
        cycle(1'b0, 32'h0, 1'b1, 32'h0001_0010, 8'h3C, 1'b0);
        cycle(1'b1, 32'h0000_0010, 1'b0, 32'h0, 8'h00, 1'b0);
        chk("no alias 1_0010", bus.rdata_o, 8'hA5);
        cycle(1'b1, 32'h0002_0010, 1'b0, 32'h0, 8'h00, 1'b0);
        chk("alias 2_0010", bus.rdata_o, 8'hA5);
        cycle(1'b1, 32'h0001_0010, 1'b0, 32'h0, 8'h00, 1'b0);
        chk("rd 1_0010", bus.rdata_o, 8'h3C);

        // five pushes to IO_ADDR with the sink stalled
        for (int i = 1; i <= 5; i++) cycle(1'b0, 32'h0, 1'b1, IO_A, 8'(i), 1'b0);
`ifdef CPU_RAM_MMIO_EN
        chk("mmio valid", {7'b0, bus.io_valid_o}, 8'h01);
        chk("mmio ovf", {7'b0, bus.io_ovf_o}, 8'h01);
        cycle(1'b1, IO_A, 1'b0, 32'h0, 8'h00, 1'b0);
        chk("status", bus.rdata_o, 8'h84);
        for (int i = 1; i <= 4; i++) begin
            chk("drain head", bus.io_data_o, 8'(i));
            cycle(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b1);
        end
        chk("drained", {7'b0, bus.io_valid_o}, 8'h00);
        cycle(1'b1, IO_A, 1'b0, 32'h0, 8'h00, 1'b0);
        chk("status empty", bus.rdata_o, 8'h80);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, IO_A, 8'(8'h10 * (i + 1)), 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b1);
        chk("mid-drain head", bus.io_data_o, 8'h20);
`else
        chk("no mmio valid", {7'b0, bus.io_valid_o}, 8'h00);
        chk("no mmio ovf", {7'b0, bus.io_ovf_o}, 8'h00);
        cycle(1'b1, IO_A, 1'b0, 32'h0, 8'h00, 1'b0);
        chk("io as ram", bus.rdata_o, 8'h05);
`endif

        // asynchronous reset between edges
        bus.re_i = 1'b0; bus.we_i = 1'b0; bus.io_ready_i = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async rst valid", {7'b0, bus.io_valid_o}, 8'h00);
        chk("async rst ovf", {7'b0, bus.io_ovf_o}, 8'h00);
        chk("async rst rdata", bus.rdata_o, 8'h00);
        @(negedge dclk);
        rst = 1'b0;
        cycle(1'b1, 32'h101, 1'b0, 32'h0, 8'h00, 1'b0);
        chk("ram kept", bus.rdata_o, 8'h33);

        // randomized traffic over a pre-initialised address pool
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, {15'h0, pool[i]}, 8'($urandom), 1'b0);
        for (int n = 0; n < 800; n++) begin
            logic [31:0] ra = ($urandom_range(0, 7) == 0) ? IO_A : rand_addr();
            logic [31:0] wa = ($urandom_range(0, 3) == 0) ? IO_A : rand_addr();
            cycle(1'($urandom), ra, 1'($urandom), wa, 8'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
